// File: rtl/increment_register_pkg.sv
// Shared constants and types for the increment_register event counters.
// Holds the default counter width and the matching counter-value type.
package increment_register_pkg;

    localparam int CNT_WIDTH_DEF = 20;

    typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

endpackage

// File: rtl/event_counter.sv
// Single resettable wrap-around event counter.
// Ports: clk, reset (sync, active-low), en (count event), count (value).
module event_counter
    import increment_register_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Reset wins over en; the add wraps naturally modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/increment_register.sv
// Three independent read-only event counters (instruction, mem access,
// mem correction). Ports: clk, reset (sync, active-low), three *_Ex
// event inputs and three registered *_Reg count outputs.
module increment_register
    import increment_register_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Instruc_Count_Ex,
    input  logic                 MEM_Acc_Ex,
    input  logic                 MEM_Correct_Ex,
    output logic [CNT_WIDTH-1:0] Instruc_Reg,
    output logic [CNT_WIDTH-1:0] MEM_Acc_Reg,
    output logic [CNT_WIDTH-1:0] MEM_Correct_Reg
);

    event_counter #(.WIDTH(CNT_WIDTH)) u_instr (
        .clk   (clk),
        .reset (reset),
        .en    (Instruc_Count_Ex),
        .count (Instruc_Reg)
    );

    event_counter #(.WIDTH(CNT_WIDTH)) u_acc (
        .clk   (clk),
        .reset (reset),
        .en    (MEM_Acc_Ex),
        .count (MEM_Acc_Reg)
    );

    event_counter #(.WIDTH(CNT_WIDTH)) u_corr (
        .clk   (clk),
        .reset (reset),
        .en    (MEM_Correct_Ex),
        .count (MEM_Correct_Reg)
    );

endmodule

// File: tb/tb_increment_register.sv
// Self-checking bench for increment_register: scoreboard of expected
// counts for a 20-bit instance and a 4-bit instance used for wrap-around.
module tb_increment_register;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ins_ex = 1'b0;
    logic acc_ex = 1'b0;
    logic cor_ex = 1'b0;

    logic [19:0] ins_reg, acc_reg, cor_reg;
    logic [3:0]  w_ins, w_acc, w_cor;

    always #5 clk = ~clk;

    increment_register dut (
        .clk             (clk),
        .reset           (reset),
        .Instruc_Count_Ex(ins_ex),
        .MEM_Acc_Ex      (acc_ex),
        .MEM_Correct_Ex  (cor_ex),
        .Instruc_Reg     (ins_reg),
        .MEM_Acc_Reg     (acc_reg),
        .MEM_Correct_Reg (cor_reg)
    );

    increment_register #(.CNT_WIDTH(4)) u_wrap (
        .clk             (clk),
        .reset           (reset),
        .Instruc_Count_Ex(ins_ex),
        .MEM_Acc_Ex      (acc_ex),
        .MEM_Correct_Ex  (cor_ex),
        .Instruc_Reg     (w_ins),
        .MEM_Acc_Reg     (w_acc),
        .MEM_Correct_Reg (w_cor)
    );

    typedef struct {
        logic [19:0] ins, acc, cor;
        logic [3:0]  wins, wacc, wcor;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference counts, advanced once per driven step.
    logic [19:0] m_ins = '0, m_acc = '0, m_cor = '0;
    logic [3:0]  m_wins = '0, m_wacc = '0, m_wcor = '0;
    exp_t last;

    task automatic check(input string tag, input logic [19:0] obs,
                         input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%05h expected 0x%05h", tag, obs, exp);
        end
    endtask

    // Drive one edge worth of stimulus, push the expected result, then
    // compare after the edge. Also checks that outputs did not move
    // between edges (reset/event changes have no asynchronous effect).
    task automatic step(input logic i, input logic a, input logic c,
                        input logic r);
        exp_t e;
        ins_ex = i;
        acc_ex = a;
        cor_ex = c;
        reset  = r;
        if (!r) begin
            m_ins = '0; m_acc = '0; m_cor = '0;
            m_wins = '0; m_wacc = '0; m_wcor = '0;
        end else begin
            m_ins  = m_ins + 20'(i);
            m_acc  = m_acc + 20'(a);
            m_cor  = m_cor + 20'(c);
            m_wins = m_wins + 4'(i);
            m_wacc = m_wacc + 4'(a);
            m_wcor = m_wcor + 4'(c);
        end
        e.ins = m_ins; e.acc = m_acc; e.cor = m_cor;
        e.wins = m_wins; e.wacc = m_wacc; e.wcor = m_wcor;
        sb.push_back(e);
        #2;
        if (n_cmp > 0) begin
            check("hold_ins", ins_reg, last.ins);
            check("hold_acc", acc_reg, last.acc);
            check("hold_cor", cor_reg, last.cor);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("ins", ins_reg, e.ins);
        check("acc", acc_reg, e.acc);
        check("cor", cor_reg, e.cor);
        check("w_ins", 20'(w_ins), 20'(e.wins));
        check("w_acc", 20'(w_acc), 20'(e.wacc));
        check("w_cor", 20'(w_cor), 20'(e.wcor));
        last = e;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset held with all events high: nothing accumulates.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            check("rst_ins_zero", ins_reg, 20'h0);
        end

        // Release reset: two counters run, one idle.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
        check("run5_ins", ins_reg, 20'd5);
        check("run5_acc", acc_reg, 20'd5);
        check("run5_cor", cor_reg, 20'd0);

        // All three simultaneously.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b1);
        check("run8_ins", ins_reg, 20'd8);
        check("run8_acc", acc_reg, 20'd8);
        check("run8_cor", cor_reg, 20'd3);

        // One-edge reset mid-count with events high.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("midrst_ins", ins_reg, 20'd0);
        check("midrst_cor", cor_reg, 20'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("resume_ins", ins_reg, 20'd1);
        check("resume_acc", acc_reg, 20'd1);
        check("resume_cor", cor_reg, 20'd1);

        // Alternating events for 10 edges: 5 high samples each.
        for (int k = 0; k < 10; k++) begin
            step(k % 2 == 0, k % 2 == 1, k % 2 == 0, 1'b1);
        end
        check("alt_ins", ins_reg, 20'd6);
        check("alt_acc", acc_reg, 20'd6);
        check("alt_cor", cor_reg, 20'd6);

        // Wrap-around on the narrow instance, instruction counter only.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("wrap_pre", 20'(w_ins), 20'hE);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("wrap_max", 20'(w_ins), 20'hF);
        check("wide_15", ins_reg, 20'd15);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("wrap_zero", 20'(w_ins), 20'h0);
        check("wrap_acc", 20'(w_acc), 20'h0);
        check("wrap_cor", 20'(w_cor), 20'h0);
        check("wide_16", ins_reg, 20'd16);

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_drain: observed %0d left expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
